// File: rtl/attn_score_scale_4x4_if.sv
// Bus bundle for attn_score_scale_4x4: run handshake, 4x4 score inputs, scaled outputs and row maxima.
// Element (r,c) lives at index 4*r+c in a_i and s_o; m_o[r] is the maximum of scaled row r.
interface attn_score_scale_4x4_if;
    logic        start_i;
    logic [31:0] a_i [16];
    logic        busy_o;
    logic        done_o;
    logic [31:0] s_o [16];
    logic [31:0] m_o [4];

    modport master (output start_i, a_i, input busy_o, done_o, s_o, m_o);
    modport slave  (input start_i, a_i, output busy_o, done_o, s_o, m_o);
endinterface

// File: rtl/attn_score_scale_4x4.sv
// Serial 2^-SHIFT FP32 score scaler with per-row max, feeding the 4x4 softmax.
// Optional feature: define CAUSAL_MASK_EN to replace upper-triangle elements (c>r) with -100.0.
module attn_score_scale_4x4 #(
    parameter int SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    attn_score_scale_4x4_if.slave    bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] SHIFT_E = 8'(SHIFT);
`ifdef CAUSAL_MASK_EN
    localparam logic [31:0] MASK_VAL = 32'hC2C8_0000;
`endif

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic [31:0] max_q, max_d;
    logic [31:0] elem;
    logic [31:0] snap_q [16];
    logic [31:0] s_q [16];
    logic [31:0] m_q [4];

    // Exponent-only scaling; anything that would land at or below e==0 is flushed to signed zero.
    function automatic logic [31:0] scale(input logic [31:0] w);
        logic [7:0] e;
        e = w[30:23];
        if (e == 8'hFF)        return w;
        else if (e <= SHIFT_E) return {w[31], 31'b0};
        else                   return {w[31], e - SHIFT_E, w[22:0]};
    endfunction

    function automatic logic [31:0] order_key(input logic [31:0] w);
        return w[31] ? ~w : (w | 32'h8000_0000);
    endfunction

    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        max_d   = max_q;
        elem    = scale(snap_q[idx_q]);
`ifdef CAUSAL_MASK_EN
        if (idx_q[1:0] > idx_q[3:2]) elem = MASK_VAL;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_RUN;
                    idx_d   = 4'd0;
                end
            end
            ST_RUN: begin
                // Column 0 seeds the running max; ties keep the earlier column.
                if (idx_q[1:0] == 2'd0 || order_key(elem) > order_key(max_q)) max_d = elem;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the snapshot is a data store consumed only after a start, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.start_i) begin
            for (int i = 0; i < 16; i++) snap_q[i] <= bus.a_i[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
            max_q   <= 32'h0;
            for (int i = 0; i < 16; i++) s_q[i] <= 32'h0;
            for (int i = 0; i < 4; i++)  m_q[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            max_q   <= max_d;
            if (state_q == ST_RUN) begin
                s_q[idx_q] <= elem;
                if (idx_q[1:0] == 2'd3) m_q[idx_q[3:2]] <= max_d;
            end
        end
    end

    assign bus.busy_o = (state_q != ST_IDLE);
    assign bus.done_o = done_q;
    assign bus.s_o    = s_q;
    assign bus.m_o    = m_q;
endmodule
